// File: rtl/dct_coef_engine.sv
// dct_coef_engine: sequential 2D DCT-II coefficient engine, one coefficient per start.
// Optional macro DCT_LEVEL_SHIFT_EN: level-shift pixels to signed before the multiply.
module dct_coef_engine #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int FRAC   = 8,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(N)-1:0]     k1,
  input  logic [$clog2(N)-1:0]     k2,
  output logic                     pix_rd,
  output logic [$clog2(N)-1:0]     pix_n1,
  output logic [$clog2(N)-1:0]     pix_n2,
  input  logic [DATA_W-1:0]        pix_data,
  output logic                     busy,
  output logic                     done,
  output logic signed [OUT_W-1:0]  coef
);

  localparam int LW  = $clog2(N);
  localparam int CW  = FRAC + 2;
  localparam int TW  = CW;
  localparam int PW  = DATA_W + 1;
  localparam int PPW = PW + TW;
  localparam int AW  = PPW + 2 * LW + 1;
  localparam logic [LW-1:0] LMAX = LW'(N - 1);
  localparam real PI = 3.14159265358979323846;

  localparam logic signed [2*CW-1:0] HALF_C =
    {{(2*CW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] HALF_A =
    {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // round(cos(m*pi/2N) * 2^FRAC), evaluated at elaboration only
  function automatic int cos_q(int m);
    real x, s, tm, sc;
    bit  neg;
    x   = PI * m / (2.0 * N);
    neg = 1'b0;
    if (x > PI / 2.0) begin
      x   = PI - x;
      neg = 1'b1;
    end
    s  = 1.0;
    tm = 1.0;
    for (int i = 1; i <= 12; i++) begin
      tm = -tm * x * x / ((2 * i - 1) * (2 * i));
      s  = s + tm;
    end
    sc = 1.0;
    for (int i = 0; i < FRAC; i++) sc = sc * 2.0;
    cos_q = $rtoi(s * sc + 0.5);
    if (neg) cos_q = -cos_q;
  endfunction

  logic signed [CW-1:0] cos_tab [2*N];

  for (genvar m = 0; m < 2 * N; m++) begin : g_tab
    localparam int V = cos_q(m);
    assign cos_tab[m] = CW'(V);
  end

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   pix_rd_q, pix_rd_d;
  logic [LW-1:0]          pix_n1_q, pix_n1_d;
  logic [LW-1:0]          pix_n2_q, pix_n2_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic signed [OUT_W-1:0] coef_q, coef_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [LW-1:0]          k1_q, k1_d;
  logic [LW-1:0]          k2_q, k2_d;
  logic                   rd_v_q, rd_v_d;
  logic signed [TW-1:0]   t_q, t_d;

  logic [LW+1:0]          p1, p2;
  logic signed [CW-1:0]   c1, c2;
  logic signed [2*CW-1:0] cc;
  logic signed [PW-1:0]   px;
  logic signed [PPW-1:0]  pp;
  logic signed [AW-1:0]   rnd;

  always_comb begin
    // fold (2n+1)*k mod 4N onto the half-period table
    p1 = {1'b0, pix_n1_q, 1'b1} * {2'b00, k1_q};
    p2 = {1'b0, pix_n2_q, 1'b1} * {2'b00, k2_q};
    c1 = p1[LW+1] ? -cos_tab[p1[LW:0]] : cos_tab[p1[LW:0]];
    c2 = p2[LW+1] ? -cos_tab[p2[LW:0]] : cos_tab[p2[LW:0]];
    cc = (2*CW)'(c1) * (2*CW)'(c2);
    t_d = TW'((cc + HALF_C) >>> FRAC);
`ifdef DCT_LEVEL_SHIFT_EN
    px = {{2{~pix_data[DATA_W-1]}}, pix_data[DATA_W-2:0]};
`else
    px = $signed({1'b0, pix_data});
`endif
    pp = PPW'(px) * PPW'(t_q);
  end

  always_comb begin
    state_d  = state_q;
    pix_rd_d = 1'b0;
    pix_n1_d = '0;
    pix_n2_d = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    coef_d   = coef_q;
    k1_d     = k1_q;
    k2_d     = k2_q;
    rd_v_d   = pix_rd_q;
    acc_d    = acc_q;
    if (rd_v_q) acc_d = acc_q + AW'(pp);
    rnd = (acc_d + HALF_A) >>> FRAC;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          pix_rd_d = 1'b1;
          busy_d   = 1'b1;
          acc_d    = '0;
          k1_d     = k1;
          k2_d     = k2;
        end
      end
      FETCH: begin
        if (pix_n1_q == LMAX && pix_n2_q == LMAX) begin
          state_d = DRAIN;
        end else begin
          pix_rd_d = 1'b1;
          if (pix_n2_q == LMAX) begin
            pix_n1_d = pix_n1_q + LW'(1);
          end else begin
            pix_n1_d = pix_n1_q;
            pix_n2_d = pix_n2_q + LW'(1);
          end
        end
      end
      DRAIN: begin
        if (rnd > MAXV)      coef_d = MAXV[OUT_W-1:0];
        else if (rnd < MINV) coef_d = MINV[OUT_W-1:0];
        else                 coef_d = OUT_W'(rnd);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pix_rd_q <= 1'b0;
      pix_n1_q <= '0;
      pix_n2_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      coef_q   <= '0;
      acc_q    <= '0;
      k1_q     <= '0;
      k2_q     <= '0;
      rd_v_q   <= 1'b0;
      t_q      <= '0;
    end else begin
      state_q  <= state_d;
      pix_rd_q <= pix_rd_d;
      pix_n1_q <= pix_n1_d;
      pix_n2_q <= pix_n2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      coef_q   <= coef_d;
      acc_q    <= acc_d;
      k1_q     <= k1_d;
      k2_q     <= k2_d;
      rd_v_q   <= rd_v_d;
      t_q      <= t_d;
    end
  end

  assign pix_rd = pix_rd_q;
  assign pix_n1 = pix_n1_q;
  assign pix_n2 = pix_n2_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign coef   = coef_q;

endmodule

// File: tb/tb_dct_coef_engine.sv
// tb_dct_coef_engine: scoreboard bench for dct_coef_engine.
// Reference computes the DCT sum directly from cosines with real math.
module tb_dct_coef_engine;

  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int FRAC   = 8;
  localparam int OUT_W  = 16;
  localparam int LW     = 3;
  localparam int NN     = N * N;
  localparam int LAT    = NN + 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic [LW-1:0]           k1 = '0;
  logic [LW-1:0]           k2 = '0;
  logic                    pix_rd;
  logic [LW-1:0]           pix_n1;
  logic [LW-1:0]           pix_n2;
  logic [DATA_W-1:0]       pix_data = '0;
  logic                    busy;
  logic                    done;
  logic signed [OUT_W-1:0] coef;

  dct_coef_engine #(
    .N(N), .DATA_W(DATA_W), .FRAC(FRAC), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .k1(k1), .k2(k2),
    .pix_rd(pix_rd), .pix_n1(pix_n1), .pix_n2(pix_n2),
    .pix_data(pix_data),
    .busy(busy), .done(done), .coef(coef)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int img [NN];

  // pixel memory: data one cycle after the read strobe, junk otherwise
  always @(posedge clk)
    pix_data <= pix_rd ? DATA_W'(img[pix_n1 * N + pix_n2])
                       : DATA_W'($urandom);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int cq(int k, int n);
    real v;
    v = $cos((2 * n + 1) * k * 3.14159265358979323846 / (2.0 * N))
        * (2.0 ** FRAC);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic int ref_coef(int a, int b);
    longint acc, t, px, r, lim;
    acc = 0;
    for (int n1 = 0; n1 < N; n1++)
      for (int n2 = 0; n2 < N; n2++) begin
        t  = (longint'(cq(a, n1)) * cq(b, n2) + (1 << (FRAC - 1))) >>> FRAC;
        px = img[n1 * N + n2];
`ifdef DCT_LEVEL_SHIFT_EN
        px = px - (1 << (DATA_W - 1));
`endif
        acc += px * t;
      end
    r   = (acc + (1 << (FRAC - 1))) >>> FRAC;
    lim = (longint'(1) << (OUT_W - 1));
    if (r > lim - 1) r = lim - 1;
    if (r < -lim)    r = -lim;
    return int'(r);
  endfunction

  typedef struct {
    int coef;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  bit   op_active = 1'b0;
  int   op_base   = 0;

  // monitor: protocol checks per cycle, scoreboard pop on done
  always @(negedge clk) begin
    int j;
    exp_t e;
    if (!reset) begin
      if (op_active) begin
        j = cyc - op_base;
        if (j >= 1 && j <= LAT) begin
          check("pix_rd", pix_rd, j <= NN);
          check("busy", busy, j <= NN + 1);
          if (j <= NN) begin
            check("pix_n1", pix_n1, (j - 1) / N);
            check("pix_n2", pix_n2, (j - 1) % N);
          end else begin
            check("pix_n1_idle", pix_n1, 0);
            check("pix_n2_idle", pix_n2, 0);
          end
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("coef", coef, e.coef);
          check("done_cycle", cyc, e.done_cyc);
        end
      end
    end
  end

  // call at a negedge: drives start and records the expectation
  task automatic issue(int a, int b, bit push);
    start = 1'b1;
    k1 = LW'(a);
    k2 = LW'(b);
    op_base = cyc;
    op_active = push;
    if (push) sb.push_back('{ref_coef(a, b), cyc + LAT});
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run(int a, int b);
    @(negedge clk);
    issue(a, b, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic fill(int v);
    for (int i = 0; i < NN; i++) img[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NN; i++) img[i] = $urandom_range(0, 255);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, j;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_pix_rd", pix_rd, 0);
    check("rst_n1", pix_n1, 0);
    check("rst_n2", pix_n2, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coef", coef, 0);
    reset = 1'b0;

    fill(128);
    run(0, 0);
`ifdef DCT_LEVEL_SHIFT_EN
    check("dc_128", coef, 0);
`else
    check("dc_128", coef, 8192);
`endif
    fill(255);
    run(0, 0);
`ifdef DCT_LEVEL_SHIFT_EN
    check("dc_255", coef, 8128);
`else
    check("dc_255", coef, 16320);
`endif
    fill(0);
    for (int i = 0; i < N; i++) img[i] = 100;
    run(4, 0);
    check("row_k40", coef, 566);
    fill(200);
    run(4, 0);
    check("const_k40", coef, 0);

    // starts while busy and in DONE are ignored; IDLE start accepted
    fill_rand();
    @(negedge clk);
    issue(1, 2, 1'b1);
    c = cyc;
    j = 0;
    while (j < LAT) begin
      @(negedge clk);
      j = cyc - c;
      start = (j == 10) || (j == LAT);
      if (j == 10) begin
        k1 = 3'd7;
        k2 = 3'd7;
      end
    end
    @(negedge clk);
    issue(3, 5, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset mid-operation abandons the run
    fill_rand();
    @(negedge clk);
    issue(2, 3, 1'b1);
    c = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc - c < 30) @(negedge clk);
    reset = 1'b1;
    op_active = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", pix_rd, 0);
    check("mid_rst_n1", pix_n1, 0);
    check("mid_rst_n2", pix_n2, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_coef", coef, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    run(2, 3);

    // reset wins over start
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", busy, 0);

    for (int r = 0; r < 20; r++) begin
      fill_rand();
      if (r % 4 == 0) fill($urandom_range(0, 255));
      run($urandom_range(0, N - 1), $urandom_range(0, N - 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
